// File: rtl/alu_issue.sv
// alu_issue: request FIFO plus a three-state issue/write-back sequencer.
// It feeds the ALU (ain comes from an accumulator shadow) and strobes the
// ALU result into the downstream accumulator once per retired operation.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready.
// in_ready is !full, computed only from registered occupancy, so it never
// depends on in_valid or on a pop in the same cycle. in_valid/in_opcode/
// in_operand may change freely while in_ready is low.
module alu_issue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_opcode,
  input  logic [WIDTH-1:0] in_operand,
  output logic [2:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_ain,
  output logic [WIDTH-1:0] alu_bin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             acc_load,
  output logic [WIDTH-1:0] acc_data,
  output logic             zero_flag,
  output logic             busy,
  output logic [CNT_W-1:0] retired_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_mem_q   [DEPTH];
  logic [2:0]       op_mem_d   [DEPTH];
  logic [WIDTH-1:0] opnd_mem_q [DEPTH];
  logic [WIDTH-1:0] opnd_mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] acc_sh_q, acc_sh_d;
  logic [2:0]       alu_opcode_q, alu_opcode_d;
  logic [WIDTH-1:0] alu_ain_q, alu_ain_d;
  logic [WIDTH-1:0] alu_bin_q, alu_bin_d;
  logic             acc_load_q, acc_load_d;
  logic [WIDTH-1:0] acc_data_q, acc_data_d;
  logic             zero_flag_q, zero_flag_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(DEPTH));
  assign push       = in_valid && !fifo_full;
  // A new op can only be launched when the ALU is not mid-operation.
  assign pop        = ((state_q == S_IDLE) || (state_q == S_WB)) && !fifo_empty;

  // Next-state: FIFO bookkeeping, sequencer, ALU operand and result capture.
  always_comb begin
    state_d      = state_q;
    op_mem_d     = op_mem_q;
    opnd_mem_d   = opnd_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    acc_sh_d     = acc_sh_q;
    alu_opcode_d = alu_opcode_q;
    alu_ain_d    = alu_ain_q;
    alu_bin_d    = alu_bin_q;
    acc_load_d   = 1'b0;
    acc_data_d   = acc_data_q;
    zero_flag_d  = zero_flag_q;
    retired_d    = retired_q;

    if (push) begin
      op_mem_d[wr_ptr_q]   = in_opcode;
      opnd_mem_d[wr_ptr_q] = in_operand;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d     = rd_ptr_q + 1'b1;
      alu_opcode_d = op_mem_q[rd_ptr_q];
      alu_bin_d    = opnd_mem_q[rd_ptr_q];
      // acc_sh_q already holds the previous result when popping from WB.
      alu_ain_d    = acc_sh_q;
    end

    if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (AW+1)'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        acc_data_d  = alu_result;
        acc_sh_d    = alu_result;
        zero_flag_d = alu_zero;
        acc_load_d  = 1'b1;
        state_d     = S_WB;
      end
      S_WB: begin
        retired_d = retired_q + 1'b1;
        state_d   = pop ? S_ISSUE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards queued and in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        op_mem_q[i]   <= '0;
        opnd_mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      acc_sh_q     <= '0;
      alu_opcode_q <= '0;
      alu_ain_q    <= '0;
      alu_bin_q    <= '0;
      acc_load_q   <= 1'b0;
      acc_data_q   <= '0;
      zero_flag_q  <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      op_mem_q     <= op_mem_d;
      opnd_mem_q   <= opnd_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      acc_sh_q     <= acc_sh_d;
      alu_opcode_q <= alu_opcode_d;
      alu_ain_q    <= alu_ain_d;
      alu_bin_q    <= alu_bin_d;
      acc_load_q   <= acc_load_d;
      acc_data_q   <= acc_data_d;
      zero_flag_q  <= zero_flag_d;
      retired_q    <= retired_d;
    end
  end

  assign in_ready      = !fifo_full;
  assign busy          = !fifo_empty || (state_q != S_IDLE);
  assign alu_opcode    = alu_opcode_q;
  assign alu_ain       = alu_ain_q;
  assign alu_bin       = alu_bin_q;
  assign acc_load      = acc_load_q;
  assign acc_data      = acc_data_q;
  assign zero_flag     = zero_flag_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small combinational ALU model.
// Cycle k is the period after rising edge k; outputs are sampled at the
// falling edge inside the cycle and inputs are changed there too.
module tb_alu_issue;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_opcode;
  logic [W-1:0] in_operand;
  logic [2:0]   alu_opcode;
  logic [W-1:0] alu_ain;
  logic [W-1:0] alu_bin;
  logic [W-1:0] alu_result;
  logic         alu_zero;
  logic         acc_load;
  logic [W-1:0] acc_data;
  logic         zero_flag;
  logic         busy;
  logic [3:0]   retired_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] v;
  } req_t;

  req_t         req_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           got_cyc[$];
  logic         zf_q[$];
  logic         rdy_log[$];
  logic [3:0]   cnt_log[$];

  alu_issue #(.WIDTH(W), .DEPTH(4), .CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_operand    (in_operand),
    .alu_opcode    (alu_opcode),
    .alu_ain       (alu_ain),
    .alu_bin       (alu_bin),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .acc_load      (acc_load),
    .acc_data      (acc_data),
    .zero_flag     (zero_flag),
    .busy          (busy),
    .retired_count (retired_count)
  );

  // ALU model: 000 pass bin, 001 add, 010 subtract.
  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      3'b000:  alu_result = alu_bin;
      3'b001:  alu_result = alu_ain + alu_bin;
      3'b010:  alu_result = alu_ain - alu_bin;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_logs();
    got_q.delete();
    got_cyc.delete();
    zf_q.delete();
    rdy_log.delete();
    cnt_log.delete();
    exp_q.delete();
    cyc = 0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    req_q.delete();
    clear_logs();
  endtask

  // Driver: offers the head of req_q each cycle, logs outputs each cycle.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      logic push_now;
      if (req_q.size() > 0) begin
        in_valid   = 1'b1;
        in_opcode  = req_q[0].op;
        in_operand = req_q[0].v;
      end else begin
        in_valid   = 1'b0;
        in_opcode  = '0;
        in_operand = '0;
      end
      push_now = (req_q.size() > 0) && in_ready;
      @(negedge clk);
      cyc++;
      if (push_now) req_q.delete(0);
      if (acc_load) begin
        got_q.push_back(acc_data);
        got_cyc.push_back(cyc);
        zf_q.push_back(zero_flag);
      end
      rdy_log.push_back(in_ready);
      cnt_log.push_back(retired_count);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (alu_opcode !== 3'b000) begin errors++; $display("FAIL reset_alu_opcode: got %h expected 0", alu_opcode); end
    checks++; if (alu_ain !== 8'h00) begin errors++; $display("FAIL reset_alu_ain: got %h expected 00", alu_ain); end
    checks++; if (alu_bin !== 8'h00) begin errors++; $display("FAIL reset_alu_bin: got %h expected 00", alu_bin); end
    checks++; if (acc_load !== 1'b0) begin errors++; $display("FAIL reset_acc_load: got %b expected 0", acc_load); end
    checks++; if (acc_data !== 8'h00) begin errors++; $display("FAIL reset_acc_data: got %h expected 00", acc_data); end
    checks++; if (zero_flag !== 1'b0) begin errors++; $display("FAIL reset_zero_flag: got %b expected 0", zero_flag); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (retired_count !== 4'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", retired_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    run(10);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL idle_no_load: got %0d loads expected 0", got_q.size()); end
  endtask

  task automatic test_single();
    do_reset();
    req_q.push_back('{op: 3'b000, v: 8'h5A});
    run(6);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL single_load_count: got %0d expected 1", got_q.size());
    end else begin
      checks++; if (got_cyc[0] != 3) begin errors++; $display("FAIL single_load_cycle: got %0d expected 3", got_cyc[0]); end
      checks++; if (got_q[0] !== 8'h5A) begin errors++; $display("FAIL single_acc_data: got %h expected 5a", got_q[0]); end
      checks++; if (zf_q[0] !== 1'b0) begin errors++; $display("FAIL single_zero_flag: got %b expected 0", zf_q[0]); end
    end
    checks++; if (retired_count !== 4'd1) begin errors++; $display("FAIL single_retired: got %0d expected 1", retired_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    checks++; if (acc_data !== 8'h5A) begin errors++; $display("FAIL single_acc_data_hold: got %h expected 5a", acc_data); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_d [3];
    logic         exp_z [3];
    int           exp_c [3];
    exp_d = '{8'hFF, 8'h00, 8'h00};
    exp_z = '{1'b0, 1'b1, 1'b1};
    exp_c = '{3, 5, 7};
    do_reset();
    req_q.push_back('{op: 3'b000, v: 8'hFF});
    req_q.push_back('{op: 3'b001, v: 8'h01});
    req_q.push_back('{op: 3'b010, v: 8'h00});
    run(12);
    checks++;
    if (got_q.size() != 3) begin
      errors++; $display("FAIL chain_load_count: got %0d expected 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (got_q[i] !== exp_d[i]) begin errors++; $display("FAIL chain_data[%0d]: got %h expected %h", i, got_q[i], exp_d[i]); end
        checks++; if (zf_q[i] !== exp_z[i]) begin errors++; $display("FAIL chain_zero[%0d]: got %b expected %b", i, zf_q[i], exp_z[i]); end
        checks++; if (got_cyc[i] != exp_c[i]) begin errors++; $display("FAIL chain_cycle[%0d]: got %0d expected %0d", i, got_cyc[i], exp_c[i]); end
      end
    end
    checks++; if (zero_flag !== 1'b1) begin errors++; $display("FAIL chain_zero_hold: got %b expected 1", zero_flag); end
  endtask

  task automatic test_full();
    int first_low;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] v;
      v = 8'(8'h11 * (i + 1));
      req_q.push_back('{op: 3'b000, v: v});
      exp_q.push_back(v);
    end
    run(24);
    checks++; if (req_q.size() != 0) begin errors++; $display("FAIL full_all_accepted: got %0d left expected 0", req_q.size()); end
    first_low = -1;
    for (int k = 0; k < rdy_log.size(); k++) begin
      if (rdy_log[k] === 1'b0 && first_low < 0) first_low = k + 1;
    end
    checks++; if (first_low != 7) begin errors++; $display("FAIL full_first_not_ready: got cycle %0d expected 7", first_low); end
    checks++; if (rdy_log[7] !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b expected 1", rdy_log[7]); end
    checks++;
    if (got_q.size() != 8) begin
      errors++; $display("FAIL full_load_count: got %0d expected 8", got_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        checks++; if (got_q[i] !== e) begin errors++; $display("FAIL full_order[%0d]: got %h expected %h", i, got_q[i], e); end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_q.push_back('{op: 3'b000, v: 8'h10});
    req_q.push_back('{op: 3'b001, v: 8'h20});
    req_q.push_back('{op: 3'b001, v: 8'h30});
    run(4);
    checks++; if (alu_bin !== 8'h20) begin errors++; $display("FAIL mid_issue_bin: got %h expected 20", alu_bin); end
    checks++; if (alu_ain !== 8'h10) begin errors++; $display("FAIL mid_issue_ain: got %h expected 10", alu_ain); end
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL mid_first_load_count: got %0d expected 1", got_q.size());
    end else begin
      checks++; if (got_q[0] !== 8'h10) begin errors++; $display("FAIL mid_first_data: got %h expected 10", got_q[0]); end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
    checks++; if (retired_count !== 4'd0) begin errors++; $display("FAIL mid_retired: got %0d expected 0", retired_count); end
    checks++; if (acc_load !== 1'b0) begin errors++; $display("FAIL mid_acc_load: got %b expected 0", acc_load); end
    checks++; if (acc_data !== 8'h00) begin errors++; $display("FAIL mid_acc_data: got %h expected 00", acc_data); end
    checks++; if (alu_ain !== 8'h00) begin errors++; $display("FAIL mid_alu_ain: got %h expected 00", alu_ain); end
    clear_logs();
    run(6);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mid_no_load: got %0d loads expected 0", got_q.size()); end
    clear_logs();
    req_q.push_back('{op: 3'b001, v: 8'h03});
    run(6);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL mid_next_count: got %0d expected 1", got_q.size());
    end else begin
      checks++; if (got_q[0] !== 8'h03) begin errors++; $display("FAIL mid_next_data: got %h expected 03", got_q[0]); end
      checks++; if (got_cyc[0] != 3) begin errors++; $display("FAIL mid_next_cycle: got %0d expected 3", got_cyc[0]); end
    end
  endtask

  task automatic test_counter_wrap();
    int j;
    int k;
    int m;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      req_q.push_back('{op: 3'b001, v: 8'h01});
      exp_q.push_back(8'(i + 1));
    end
    run(45);
    checks++;
    if (got_q.size() != 17) begin
      errors++; $display("FAIL wrap_load_count: got %0d expected 17", got_q.size());
    end else begin
      for (int i = 0; i < 17; i++) begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        checks++; if (got_q[i] !== e) begin errors++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, got_q[i], e); end
      end
    end
    j = -1;
    for (int i = 0; i < cnt_log.size(); i++) if (cnt_log[i] == 4'd15 && j < 0) j = i;
    k = -1;
    if (j >= 0) for (int i = j; i < cnt_log.size(); i++) if (cnt_log[i] != 4'd15 && k < 0) k = i;
    m = -1;
    if (k >= 0) for (int i = k; i < cnt_log.size(); i++) if (cnt_log[i] != cnt_log[k] && m < 0) m = i;
    checks++;
    if (j < 0 || k < 0 || m < 0) begin
      errors++; $display("FAIL wrap_sequence: got idx %0d/%0d/%0d expected 15 then 0 then 1", j, k, m);
    end else begin
      checks++; if (cnt_log[k] !== 4'd0) begin errors++; $display("FAIL wrap_after_15: got %0d expected 0", cnt_log[k]); end
      checks++; if (cnt_log[m] !== 4'd1) begin errors++; $display("FAIL wrap_after_0: got %0d expected 1", cnt_log[m]); end
    end
    checks++; if (retired_count !== 4'd1) begin errors++; $display("FAIL wrap_final: got %0d expected 1", retired_count); end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_opcode  = '0;
    in_operand = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_reset_mid();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
